maze_solver: RTL and testbench
==============================

Name: maze_solver

Overview:
- Depth-first maze-exploration controller that sits directly upstream of the 16x16 maze memory and is its sole master.
- Drives the memory's loc/rd/wr/dIn lines and consumes its dOut bit.
- Walks from cell (0,0) to goal (15,15), marking visited cells as walls, and keeps the current path on an internal move stack.
- On success, replays the path as a stream of 2-bit moves to the downstream consumer.

Parameters:
STACK_DEPTH, 256, move-stack entries (must be >= 255)
SP_W, 9, stack-pointer width (holds 0..STACK_DEPTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse in IDLE/DONE/FAIL begins a new solve
loc  output  8  memory address {x[3:0], y[3:0]}, i.e. map[x][y]
rd  output  1  memory read strobe
wr  output  1  memory write strobe
dIn  output  1  memory write data, always 1 (mark visited)
dOut  input  1  memory read data: 0 = open, 1 = wall/visited
busy  output  1  high from start accepted until DONE/FAIL
done  output  1  level, high in DONE
fail  output  1  level, high in FAIL
path_len  output  SP_W  stack depth at DONE (number of moves)
move  output  2  replayed move, valid with move_valid
move_valid  output  1  replay data valid
move_ready  input  1  consumer accepts move

Behaviour:
- Reset (async): state=IDLE; cur=(0,0); dir=0; sp=0; replay index=0. All outputs 0: loc, rd, wr, dIn, busy, done, fail, path_len, move, move_valid.
- Direction encoding: 0=right (x+1), 1=down (y+1), 2=left (x-1), 3=up (y-1). Opposite direction = dir^2.
- Memory timing: rd and wr are single-cycle strobes and are never asserted together. dOut is sampled in the cycle after rd.
- dIn is 1 whenever wr=1, otherwise 0.
- State IDLE: wait for start. On start: cur=(0,0), dir=0, sp=0, clear done/fail, set busy, go to MARK.
- State MARK: wr=1, loc=cur, dIn=1.
  - If cur==(15,15): go to DONE, path_len=sp.
  - Otherwise: dir=0, go to PROBE.
- State PROBE: compute neighbour n = cur+dir.
  - If n is out of bounds (x or y would wrap past 0/15): no strobe; advance dir, or go to BACK if dir==3.
  - Otherwise: rd=1, loc=n, go to CHECK.
- State CHECK: rd=0, sample dOut.
  - dOut==0: push dir, sp++, cur=n, go to MARK.
  - dOut==1: if dir<3, dir++ and go to PROBE; else go to BACK.
- State BACK: no strobe.
  - If sp==0: go to FAIL.
  - Otherwise: pop d, sp--, cur moves one step in direction d^2.
  - If d<3: dir=d+1, go to PROBE. If d==3: stay in BACK.
- Marking policy: the start cell is never read, only marked. Visited cells stay 1 in memory, so they are never re-entered.
- Stack cannot overflow: at most 255 moves are ever pushed.
- State DONE: busy=0, done=1.
  - Replay: move_valid=1 while index<path_len; move=stack[index], bottom first (first step from start).
  - index advances when move_valid & move_ready.
  - When index==path_len, move_valid=0.
  - A start pulse here restarts; the memory is not cleared by this block.
- State FAIL: busy=0, fail=1, path_len=0, move_valid=0. A start pulse here restarts.
- start is ignored while busy.
- Reset mid-solve returns immediately to IDLE, with any in-flight strobe dropped.

Test Plan:
- All-zero map, start pulse → 15 moves of 0 then 15 moves of 1 replayed; done=1, path_len=30. Memory shows 1 at (x,0) for x=0..15 and at (15,y) for y=0..15.
- Map all 1 except (0,0), start → fail=1, path_len=0, move_valid never high. Exactly 2 rd strobes: right and down (left and up are out of bounds).
- Dead-end map: column y=0 open for x=0..3 and (3,0) closed beyond; corridor down from (0,0) to the goal → backtrack pops 3 right-moves; final path is all moves 1 then 0, path_len=30.
- Replay with move_ready toggled 1,0,1,0 → each move held stable while move_ready=0; no move dropped or duplicated; move_valid falls after the 30th accept.
- Start pulse asserted during busy → ignored; rd/wr sequence is identical to the run without the extra pulse.
- rst asserted in CHECK mid-solve → all outputs 0 asynchronously, state IDLE; a following start re-solves from (0,0).
- Every cycle (assertion): never rd&wr; dIn==wr.

Source files
------------

// File: rtl/maze_solver.sv
// Depth-first maze walker: marks visited cells in the external 16x16 bit map, keeps the path on a move stack.
// One strobe per cycle at most; the path is replayed after DONE under a valid/ready handshake.
module maze_solver #(
  parameter int STACK_DEPTH = 256,
  parameter int SP_W        = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [7:0]      loc,
  output logic            rd,
  output logic            wr,
  output logic            dIn,
  input  logic            dOut,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [SP_W-1:0] path_len,
  output logic [1:0]      move,
  output logic            move_valid,
  input  logic            move_ready
);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_MARK, S_PROBE, S_CHECK, S_BACK, S_DONE, S_FAIL} state_t;

  state_t          state_q, state_d;
  logic [3:0]      x_q, x_d, y_q, y_d;
  logic [1:0]      dir_q, dir_d;
  logic [SP_W-1:0] sp_q, sp_d, len_q, len_d, idx_q, idx_d;
  logic [1:0]      stack_q [STACK_DEPTH];
  logic            push;
  logic [3:0]      nx, ny;
  logic            oob;
  logic [1:0]      top;

  // Neighbour in the current probe direction; oob flags a step off the grid edge.
  always_comb begin
    nx  = x_q;
    ny  = y_q;
    oob = 1'b0;
    case (dir_q)
      2'd0: begin nx = x_q + 4'd1; oob = (x_q == 4'd15); end
      2'd1: begin ny = y_q + 4'd1; oob = (y_q == 4'd15); end
      2'd2: begin nx = x_q - 4'd1; oob = (x_q == 4'd0);  end
      default: begin ny = y_q - 4'd1; oob = (y_q == 4'd0); end
    endcase
  end

  assign top = stack_q[IDX_W'(sp_q - SP_W'(1))];

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    sp_d       = sp_q;
    len_d      = len_q;
    idx_d      = idx_q;
    push       = 1'b0;
    loc        = 8'd0;
    rd         = 1'b0;
    wr         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;
    move_valid = 1'b0;
    case (state_q)
      S_MARK: begin
        busy = 1'b1;
        wr   = 1'b1;
        loc  = {x_q, y_q};
        if (x_q == 4'd15 && y_q == 4'd15) begin
          len_d   = sp_q;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          dir_d   = 2'd0;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        busy = 1'b1;
        if (oob) begin
          if (dir_q == 2'd3) state_d = S_BACK;
          else               dir_d   = dir_q + 2'd1;
        end else begin
          rd      = 1'b1;
          loc     = {nx, ny};
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (!dOut) begin
          push    = 1'b1;
          sp_d    = sp_q + SP_W'(1);
          x_d     = nx;
          y_d     = ny;
          state_d = S_MARK;
        end else if (dir_q != 2'd3) begin
          dir_d   = dir_q + 2'd1;
          state_d = S_PROBE;
        end else begin
          state_d = S_BACK;
        end
      end
      S_BACK: begin
        busy = 1'b1;
        if (sp_q == '0) begin
          len_d   = '0;
          state_d = S_FAIL;
        end else begin
          sp_d = sp_q - SP_W'(1);
          // Undo the popped move by stepping the opposite way.
          case (top)
            2'd0:    x_d = x_q - 4'd1;
            2'd1:    y_d = y_q - 4'd1;
            2'd2:    x_d = x_q + 4'd1;
            default: y_d = y_q + 4'd1;
          endcase
          if (top != 2'd3) begin
            dir_d   = top + 2'd1;
            state_d = S_PROBE;
          end
        end
      end
      S_DONE: begin
        done       = 1'b1;
        move_valid = (idx_q < len_q);
        if (move_valid && move_ready) idx_d = idx_q + SP_W'(1);
      end
      S_FAIL: fail = 1'b1;
      default: ;
    endcase
    if ((state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL) && start) begin
      x_d     = 4'd0;
      y_d     = 4'd0;
      dir_d   = 2'd0;
      sp_d    = '0;
      len_d   = '0;
      idx_d   = '0;
      state_d = S_MARK;
    end
  end

  assign dIn      = wr;
  assign path_len = len_q;
  assign move     = move_valid ? stack_q[idx_q[IDX_W-1:0]] : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= 4'd0;
      y_q     <= 4'd0;
      dir_q   <= 2'd0;
      sp_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      sp_q    <= sp_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[IDX_W-1:0]] <= dir_q;
  end
endmodule

// File: tb/tb_maze_solver.sv
// Directed bench for maze_solver with a behavioural 16x16 bit memory and hand-derived strobe/move expectations.
`timescale 1ns/1ps
module tb_maze_solver;
  localparam int SP_W = 9;

  logic            clk = 1'b0, rst = 1'b1, start = 1'b0, move_ready = 1'b0;
  logic [7:0]      loc;
  logic            rd, wr, dIn, busy, done, fail, move_valid;
  logic            dOut = 1'b0;
  logic [SP_W-1:0] path_len;
  logic [1:0]      move;

  maze_solver #(.STACK_DEPTH(256), .SP_W(SP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .loc(loc), .rd(rd), .wr(wr), .dIn(dIn),
    .dOut(dOut), .busy(busy), .done(done), .fail(fail), .path_len(path_len),
    .move(move), .move_valid(move_valid), .move_ready(move_ready)
  );

  always #5 clk = ~clk;

  logic [255:0] mem, init_mem;
  logic         load = 1'b0;
  int           rd_cnt = 0;
  logic         mv_seen = 1'b0;
  int           viol = 0;
  logic [9:0]   ev_q[$];
  logic [9:0]   exp_ev[$];
  int           n_vec = 0, n_miss = 0;

  always @(posedge clk) begin
    if (load) begin
      mem     <= init_mem;
      rd_cnt  <= 0;
      mv_seen <= 1'b0;
      ev_q.delete();
    end else begin
      if (wr) mem[loc] <= dIn;
      if (rd) begin
        dOut   <= mem[loc];
        rd_cnt <= rd_cnt + 1;
      end
      if (rd || wr) ev_q.push_back({rd, wr, loc});
      if (move_valid) mv_seen <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if ((rd && wr) || (dIn !== wr)) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_map(input logic [255:0] m);
    @(negedge clk);
    init_mem = m;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int c = 0;
    while (!(done || fail) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 3000) chk({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  // Strobe trace for the open map: straight right along y=0, then straight down x=15.
  task automatic build_zero_exp();
    exp_ev.delete();
    exp_ev.push_back({2'b01, 8'h00});
    for (int x = 1; x < 16; x++) begin
      exp_ev.push_back({2'b10, 4'(x), 4'd0});
      exp_ev.push_back({2'b01, 4'(x), 4'd0});
    end
    for (int y = 1; y < 16; y++) begin
      exp_ev.push_back({2'b10, 4'd15, 4'(y)});
      exp_ev.push_back({2'b01, 4'd15, 4'(y)});
    end
  endtask

  task automatic check_ev(input string tag);
    int nbad = 0;
    int n    = (ev_q.size() < exp_ev.size()) ? ev_q.size() : exp_ev.size();
    for (int i = 0; i < n; i++) if (ev_q[i] !== exp_ev[i]) nbad++;
    chk({tag, "_ev_cnt"}, 64'(ev_q.size()), 64'(exp_ev.size()));
    chk({tag, "_ev_bad"}, 64'(nbad), 64'd0);
  endtask

  task automatic replay(input string tag, input bit toggle, input logic [59:0] exp_mv);
    logic [59:0] got  = '0;
    logic [1:0]  held = '0;
    bit          pend = 1'b0;
    int          n    = 0;
    for (int c = 0; c < 200 && n < 30; c++) begin
      @(negedge clk);
      move_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (move_valid) begin
        if (pend) chk({tag, "_hold"}, 64'(move), 64'(held));
        if (move_ready) begin
          got[2*n +: 2] = move;
          n++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          held = move;
        end
      end
    end
    chk({tag, "_cnt"}, 64'(n), 64'd30);
    chk({tag, "_moves"}, 64'(got), 64'(exp_mv));
    @(negedge clk);
    move_ready = 1'b0;
    chk({tag, "_vfall"}, 64'(move_valid), 64'd0);
  endtask

  logic [255:0] zero_map, wall_map, dead_map;
  logic [59:0]  exp_zero, exp_dead;
  int           marked;

  initial begin
    zero_map = '0;
    wall_map = '1;
    wall_map[0] = 1'b0;
    dead_map = '1;
    for (int x = 0; x < 4; x++) dead_map[{4'(x), 4'd0}] = 1'b0;
    for (int y = 0; y < 16; y++) dead_map[{4'd0, 4'(y)}] = 1'b0;
    for (int x = 0; x < 16; x++) dead_map[{4'(x), 4'd15}] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      exp_zero[2*i +: 2] = (i < 15) ? 2'd0 : 2'd1;
      exp_dead[2*i +: 2] = (i < 15) ? 2'd1 : 2'd0;
    end
    build_zero_exp();

    #1;
    chk("reset_outs", 64'({loc, rd, wr, dIn, busy, done, fail, path_len, move, move_valid}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Open map
    load_map(zero_map);
    pulse_start();
    chk("busy_run", 64'(busy), 64'd1);
    wait_end("zero");
    chk("zero_done", 64'({done, fail, busy}), 64'b100);
    chk("zero_len", 64'(path_len), 64'd30);
    check_ev("zero");
    chk("zero_ones", 64'($countones(mem)), 64'd31);
    marked = 0;
    for (int x = 0; x < 16; x++) if (mem[{4'(x), 4'd0}]) marked++;
    for (int y = 1; y < 16; y++) if (mem[{4'd15, 4'(y)}]) marked++;
    chk("zero_cells", 64'(marked), 64'd31);
    replay("rep_zero", 1'b0, exp_zero);

    // Boxed-in start cell
    load_map(wall_map);
    pulse_start();
    wait_end("wall");
    @(negedge clk);
    chk("wall_flags", 64'({done, fail, busy}), 64'b010);
    chk("wall_len", 64'(path_len), 64'd0);
    chk("wall_rd_cnt", 64'(rd_cnt), 64'd2);
    chk("wall_mv_seen", 64'(mv_seen), 64'd0);

    // Dead-end branch along y=0, then the real corridor; replay with toggling ready
    load_map(dead_map);
    pulse_start();
    wait_end("dead");
    chk("dead_done", 64'(done), 64'd1);
    chk("dead_len", 64'(path_len), 64'd30);
    replay("rep_dead", 1'b1, exp_dead);

    // Start pulses while busy must not disturb the walk
    load_map(zero_map);
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_end("busy");
    chk("busy_len", 64'(path_len), 64'd30);
    check_ev("busy");

    // Async reset while in CHECK, then a clean re-solve
    load_map(zero_map);
    pulse_start();
    begin
      int c = 0;
      while (!rd && c < 50) begin
        @(negedge clk);
        c++;
      end
      chk("rst_saw_rd", 64'(rd), 64'd1);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_outs", 64'({loc, rd, wr, dIn, busy, done, fail, path_len, move, move_valid}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    load_map(zero_map);
    pulse_start();
    wait_end("post_rst");
    chk("post_rst_done", 64'(done), 64'd1);
    chk("post_rst_len", 64'(path_len), 64'd30);
    check_ev("post_rst");

    chk("rdwr_dIn", 64'(viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
